mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 14 +
 rtl/mem_responder_if.sv | 30 +++
 rtl/mem_responder_ram.sv | 25 ++
 rtl/mem_responder.sv | 152 +++++++++++++++
 tb/tb_mem_responder.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types for the mem_responder slice: FSM state encoding and request opcodes.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DATA = 2'd2,
    WR_DATA = 2'd3
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/mem_responder_if.sv
// Request / write-data / read-data bundle between an initiator (master) and mem_responder (slave).
interface mem_responder_if #(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 64,
  parameter int MEM_DATA_BITS = 64
) ();

  logic                     mem_req_valid;
  logic                     mem_req_opcode;
  logic [MEM_LEN_BITS-1:0]  mem_req_len;
  logic [MEM_ADDR_BITS-1:0] mem_req_addr;
  logic                     mem_wr_valid;
  logic [MEM_DATA_BITS-1:0] mem_wr_bits;
  logic                     mem_rd_valid;
  logic [MEM_DATA_BITS-1:0] mem_rd_bits;
  logic                     mem_rd_ready;

  modport master (
    output mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    output mem_wr_valid, mem_wr_bits, mem_rd_ready,
    input  mem_rd_valid, mem_rd_bits
  );

  modport slave (
    input  mem_req_valid, mem_req_opcode, mem_req_len, mem_req_addr,
    input  mem_wr_valid, mem_wr_bits, mem_rd_ready,
    output mem_rd_valid, mem_rd_bits
  );

endinterface

// File: rtl/mem_responder_ram.sv
// Word storage for mem_responder: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so they survive an aborted burst.
module mem_responder_ram #(
  parameter int DATA_BITS  = 64,
  parameter int DEPTH_BITS = 10
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_BITS-1:0] waddr,
  input  logic [DATA_BITS-1:0]  wdata,
  input  logic [DEPTH_BITS-1:0] raddr,
  output logic [DATA_BITS-1:0]  rdata
);

  logic [DATA_BITS-1:0] mem [2**DEPTH_BITS];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Burst memory responder: accepts read/write bursts and serves them from local storage.
// Optional beat counters are enabled with `define MEM_RESPONDER_STATS_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_LEN_BITS  = 8,
  parameter int MEM_ADDR_BITS = 64,
  parameter int MEM_DATA_BITS = 64,
  parameter int DEPTH_BITS    = 10,
  parameter int RD_LATENCY    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  mem_responder_if.slave        bus,
  output logic                  busy,
  output logic                  err,
  output logic [31:0]           rd_beats,
  output logic [31:0]           wr_beats
);

  localparam int BEAT_BITS = MEM_LEN_BITS + 1;
  localparam logic [3:0] LAT_INIT = (RD_LATENCY > 0) ? 4'(RD_LATENCY - 1) : 4'd0;

  state_t                   state, state_next;
  logic [DEPTH_BITS-1:0]    index, index_next;
  logic [BEAT_BITS-1:0]     beats, beats_next;
  logic [3:0]               lat_cnt, lat_next;
  logic                     err_next;
  logic                     rd_fire;
  logic                     wr_fire;
  logic                     ram_we;
  logic [MEM_DATA_BITS-1:0] ram_rdata;
  logic                     unused_addr;

  // Only the low DEPTH_BITS of the address select a word; the rest are don't-care.
  assign unused_addr = ^bus.mem_req_addr[MEM_ADDR_BITS-1:DEPTH_BITS];

  assign rd_fire = (state == RD_DATA) && bus.mem_rd_ready;
  assign wr_fire = (state == WR_DATA) && bus.mem_wr_valid;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      index   <= '0;
      beats   <= '0;
      lat_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      index   <= index_next;
      beats   <= beats_next;
      lat_cnt <= lat_next;
      err     <= err_next;
    end
  end

  always_comb begin
    state_next = state;
    index_next = index;
    beats_next = beats;
    lat_next   = lat_cnt;
    err_next   = err;

    if ((bus.mem_req_valid && (state != IDLE)) || (bus.mem_wr_valid && (state != WR_DATA))) begin
      err_next = 1'b1;
    end

    case (state)
      IDLE: begin
        if (bus.mem_req_valid) begin
          index_next = bus.mem_req_addr[DEPTH_BITS-1:0];
          beats_next = {1'b0, bus.mem_req_len} + BEAT_BITS'(1);
          lat_next   = LAT_INIT;
          if (bus.mem_req_opcode == OP_WR) begin
            state_next = WR_DATA;
          end else if (RD_LATENCY == 0) begin
            state_next = RD_DATA;
          end else begin
            state_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (lat_cnt == 4'd0) begin
          state_next = RD_DATA;
        end else begin
          lat_next = lat_cnt - 4'd1;
        end
      end
      RD_DATA: begin
        if (rd_fire) begin
          index_next = index + DEPTH_BITS'(1);
          beats_next = beats - BEAT_BITS'(1);
          if (beats == BEAT_BITS'(1)) begin
            state_next = IDLE;
          end
        end
      end
      WR_DATA: begin
        if (wr_fire) begin
          index_next = index + DEPTH_BITS'(1);
          beats_next = beats - BEAT_BITS'(1);
          if (beats == BEAT_BITS'(1)) begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // A burst interrupted by reset must not commit the beat presented in the reset cycle.
  assign ram_we = wr_fire & ~reset;

  mem_responder_ram #(
    .DATA_BITS  (MEM_DATA_BITS),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (index),
    .wdata (bus.mem_wr_bits),
    .raddr (index),
    .rdata (ram_rdata)
  );

  assign busy             = (state != IDLE);
  assign bus.mem_rd_valid = (state == RD_DATA);
  assign bus.mem_rd_bits  = (state == RD_DATA) ? ram_rdata : '0;

`ifdef MEM_RESPONDER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_beats <= '0;
      wr_beats <= '0;
    end else begin
      if (rd_fire) begin
        rd_beats <= rd_beats + 32'd1;
      end
      if (wr_fire) begin
        wr_beats <= wr_beats + 32'd1;
      end
    end
  end
`else
  assign rd_beats = '0;
  assign wr_beats = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, hand-written corner sequences,
// and randomized bursts checked against a word-array memory model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1024;

  typedef struct {
    bit          is_wr;
    logic [63:0] addr;
    int          len;
    logic [63:0] base;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        busy;
  logic        err;
  logic [31:0] rd_beats;
  logic [31:0] wr_beats;

  int          checks;
  int          errors;
  logic [63:0] model_mem [DEPTH];
  int          rd_cnt;
  int          wr_cnt;
  bit          err_exp;
  vec_t        vecs [8];

  mem_responder_if #(.MEM_LEN_BITS(8), .MEM_ADDR_BITS(64), .MEM_DATA_BITS(64)) bus ();

  mem_responder #(
    .MEM_LEN_BITS  (8),
    .MEM_ADDR_BITS (64),
    .MEM_DATA_BITS (64),
    .DEPTH_BITS    (10),
    .RD_LATENCY    (RD_LAT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .err      (err),
    .rd_beats (rd_beats),
    .wr_beats (wr_beats)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int expCount(input int n);
`ifdef MEM_RESPONDER_STATS_EN
    return n;
`else
    return 0;
`endif
  endfunction

  function automatic int wrapIdx(input logic [63:0] addr, input int offset);
    return (int'(addr[9:0]) + offset) % DEPTH;
  endfunction

  task automatic nextCycle();
    @(negedge clock);
  endtask

  task automatic applyStimulus(input logic req_valid, input logic opcode, input logic [7:0] len,
                               input logic [63:0] addr, input logic wr_valid,
                               input logic [63:0] wr_bits, input logic rd_ready);
    bus.mem_req_valid  = req_valid;
    bus.mem_req_opcode = opcode;
    bus.mem_req_len    = len;
    bus.mem_req_addr   = addr;
    bus.mem_wr_valid   = wr_valid;
    bus.mem_wr_bits    = wr_bits;
    bus.mem_rd_ready   = rd_ready;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, OP_RD, 8'd0, 64'd0, 1'b0, 64'd0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    nextCycle();
    applyIdle();
    reset = 1'b1;
    nextCycle();
    nextCycle();
    reset = 1'b0;
    err_exp = 1'b0;
    rd_cnt  = 0;
    wr_cnt  = 0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_rd_valid", bus.mem_rd_valid, 0);
    checkOutput("reset_rd_bits", bus.mem_rd_bits, 0);
    checkOutput("reset_rd_beats", rd_beats, 0);
    checkOutput("reset_wr_beats", wr_beats, 0);
  endtask

  task automatic doWrite(input logic [63:0] addr, input int len, input logic [63:0] base,
                         input bit rand_data, input bit gaps, input bit wr_with_req);
    logic [63:0] data;
    nextCycle();
    checkOutput("wr_start_busy", busy, 0);
    applyStimulus(1'b1, OP_WR, len[7:0], addr, wr_with_req, 64'hDEAD_BEEF, 1'b0);
    if (wr_with_req) err_exp = 1'b1;
    for (int b = 0; b <= len; b++) begin
      if (gaps) begin
        for (int g = 0; g < 2; g++) begin
          if ($urandom_range(0, 2) == 0) begin
            nextCycle();
            checkOutput("wr_gap_busy", busy, 1);
            applyIdle();
          end
        end
      end
      nextCycle();
      checkOutput("wr_busy", busy, 1);
      data = rand_data ? {$urandom, $urandom} : base + 64'(b);
      applyStimulus(1'b0, OP_RD, 8'd0, 64'd0, 1'b1, data, 1'b0);
      model_mem[wrapIdx(addr, b)] = data;
      wr_cnt++;
    end
    nextCycle();
    checkOutput("wr_end_busy", busy, 0);
    checkOutput("wr_end_err", err, 64'(err_exp));
    applyIdle();
  endtask

  task automatic doRead(input logic [63:0] addr, input int len, input bit use_exp,
                        input logic [63:0] exp_base, input int hold_first,
                        input bit rand_ready, input bit inject_req);
    int          cyc;
    int          beat;
    int          held;
    bit          first_seen;
    bit          prev_valid;
    bit          prev_ready;
    bit          ready;
    bit          valid;
    logic [63:0] bits;
    logic [63:0] prev_bits;
    logic [63:0] exp_data;
    nextCycle();
    applyStimulus(1'b1, OP_RD, len[7:0], addr, 1'b0, 64'd0, 1'b0);
    cyc = 0; beat = 0; held = 0; first_seen = 0;
    prev_valid = 0; prev_ready = 0; prev_bits = '0;
    while (beat <= len && cyc < 200) begin
      nextCycle();
      cyc++;
      valid = bus.mem_rd_valid;
      bits  = bus.mem_rd_bits;
      if (prev_valid && prev_ready) checkOutput("rd_no_gap", valid, 1);
      if (prev_valid && !prev_ready) begin
        checkOutput("rd_hold_valid", valid, 1);
        checkOutput("rd_hold_bits", bits, prev_bits);
      end
      if (valid) begin
        if (!first_seen) begin
          first_seen = 1;
          checkOutput("rd_latency", cyc, RD_LAT + 1);
        end
        exp_data = use_exp ? exp_base + 64'(beat) : model_mem[wrapIdx(addr, beat)];
        checkOutput("rd_data", bits, exp_data);
      end
      if (valid && beat == 0 && held < hold_first) begin
        ready = 0;
        held++;
      end else begin
        ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      applyStimulus(inject_req && cyc == 1, OP_WR, 8'd0, addr + 64'h10, 1'b0, 64'd0, ready);
      prev_valid = valid;
      prev_ready = ready;
      prev_bits  = bits;
      if (valid && ready) begin
        beat++;
        rd_cnt++;
      end
    end
    if (beat <= len) checkOutput("rd_timeout_beats", beat, len + 1);
    if (inject_req) err_exp = 1'b1;
    nextCycle();
    checkOutput("rd_end_valid", bus.mem_rd_valid, 0);
    checkOutput("rd_end_busy", busy, 0);
    checkOutput("rd_end_err", err, 64'(err_exp));
    applyIdle();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    err_exp = 0;
    rd_cnt  = 0;
    wr_cnt  = 0;
    reset   = 1'b1;
    applyIdle();

    vecs[0] = '{1'b1, 64'h5,                  0, 64'h1234};
    vecs[1] = '{1'b0, 64'h5,                  0, 64'h1234};
    vecs[2] = '{1'b1, 64'h3FE,                3, 64'h1};
    vecs[3] = '{1'b0, 64'h3FE,                3, 64'h1};
    vecs[4] = '{1'b0, 64'h0,                  1, 64'h3};
    vecs[5] = '{1'b1, 64'hFFFF_0000_0000_0100, 2, 64'hA0};
    vecs[6] = '{1'b0, 64'h100,                2, 64'hA0};
    vecs[7] = '{1'b0, 64'h7777_0000_0000_0101, 1, 64'hA1};

    doReset();

    // Preload every word so the model is fully defined before any read.
    for (int p = 0; p < 4; p++) doWrite(64'(p * 256), 255, 64'd0, 1'b1, 1'b0, 1'b0);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].is_wr) doWrite(vecs[v].addr, vecs[v].len, vecs[v].base, 1'b0, 1'b0, 1'b0);
      else doRead(vecs[v].addr, vecs[v].len, 1'b1, vecs[v].base, 0, 1'b0, 1'b0);
    end

    // Backpressure: first beat held for 5 cycles before the handshake.
    doWrite(64'h200, 1, 64'hBEEF_0000, 1'b0, 1'b0, 1'b0);
    doRead(64'h200, 1, 1'b1, 64'hBEEF_0000, 5, 1'b0, 1'b0);

    // Request during RD_WAIT is ignored but sticks err.
    doRead(64'h300, 3, 1'b0, 64'd0, 0, 1'b0, 1'b1);
    doRead(64'h310, 0, 1'b0, 64'd0, 0, 1'b0, 1'b0);

    // Write beat while idle is a protocol error and stores nothing.
    doReset();
    nextCycle();
    applyStimulus(1'b0, OP_RD, 8'd0, 64'd0, 1'b1, 64'hBAD0_BAD0, 1'b0);
    err_exp = 1'b1;
    nextCycle();
    checkOutput("stray_wr_err", err, 1);
    checkOutput("stray_wr_busy", busy, 0);
    applyIdle();
    doRead(64'h0, 3, 1'b0, 64'd0, 0, 1'b0, 1'b0);

    // Write beat in the acceptance cycle is ignored and flagged.
    doReset();
    doWrite(64'h220, 1, 64'hC0DE_0000, 1'b0, 1'b0, 1'b1);
    doRead(64'h220, 1, 1'b1, 64'hC0DE_0000, 0, 1'b0, 1'b0);

    // Reset after 2 of 4 write beats: later words keep their old contents.
    doReset();
    nextCycle();
    applyStimulus(1'b1, OP_WR, 8'd3, 64'h40, 1'b0, 64'd0, 1'b0);
    for (int b = 0; b < 2; b++) begin
      nextCycle();
      applyStimulus(1'b0, OP_RD, 8'd0, 64'd0, 1'b1, 64'h5100 + 64'(b), 1'b0);
      model_mem[64 + b] = 64'h5100 + 64'(b);
    end
    nextCycle();
    applyStimulus(1'b0, OP_RD, 8'd0, 64'd0, 1'b1, 64'h5102, 1'b0);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    applyIdle();
    rd_cnt = 0;
    wr_cnt = 0;
    checkOutput("midwr_reset_busy", busy, 0);
    checkOutput("midwr_reset_err", err, 0);
    checkOutput("midwr_reset_rd_valid", bus.mem_rd_valid, 0);
    doRead(64'h40, 3, 1'b0, 64'd0, 0, 1'b0, 1'b0);

    // Beat counters over exactly 4 write and 4 read beats.
    doReset();
    doWrite(64'h180, 3, 64'h900, 1'b0, 1'b0, 1'b0);
    doRead(64'h180, 3, 1'b1, 64'h900, 0, 1'b0, 1'b0);
    checkOutput("stats_wr_beats", wr_beats, expCount(4));
    checkOutput("stats_rd_beats", rd_beats, expCount(4));

    // Randomized bursts against the memory model.
    doReset();
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        doWrite({$urandom, $urandom}, $urandom_range(0, 15), 64'd0, 1'b1, 1'b1, 1'b0);
      else
        doRead({$urandom, $urandom}, $urandom_range(0, 15), 1'b0, 64'd0, 0, 1'b1, 1'b0);
    end
    checkOutput("rand_wr_beats", wr_beats, expCount(wr_cnt));
    checkOutput("rand_rd_beats", rd_beats, expCount(rd_cnt));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
